multicycle_control_fsm: RTL and testbench

//  Main controller for the multicycle RV32I datapath. Replaces the single-cycle opcode decoder.

---
 rtl/multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main controller for the multicycle RV32I datapath. Each instruction is
//   walked through FETCH / DECODE / execute / writeback states. The
//   controller drives the shared-ALU, shared-memory and register-file
//   control strobes. It stalls on the memory-ready handshake, flags
//   unsupported opcodes and counts retired instructions.
//
// Parameters
//   MEM_HANDSHAKE   1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready ignored
//   TRAP_ON_ILLEGAL 1: illegal opcode parks in TRAP until reset; 0: pulse flag, refetch
//   CNT_W           width of the retired-instruction counter
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op                instr[6:0] from the instruction register
//   mem_ready         memory finishes the current access this cycle
//   zero              ALU zero flag, used by BEQ
//   pc_write          PC load enable
//   adr_src           memory address select (0 PC, 1 ALU result register)
//   mem_write         data memory write strobe
//   ir_write          instruction register load enable
//   reg_write         register file write enable
//   result_src        00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a         00 PC, 01 OldPC, 10 rs1
//   alu_src_b         00 rs2, 01 ImmExt, 10 constant 4
//   alu_op            00 add, 01 sub, 10 decode by funct
//   imm_src           immediate format, decoded straight from op
//   illegal_instr     unsupported opcode seen in DECODE (held while trapped)
//   instret           retired-instruction count

module multicycle_control_fsm #(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
    } state_t;

    state_t state, next_state;
    logic   ready;
    logic   pc_update;
    logic   branch;
    logic   retire;

    // With the handshake disabled every memory access completes in one cycle.
    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // A taken branch loads the PC alongside the unconditional updates.
    assign pc_write = pc_update | (branch & zero);

    // State register and retired-instruction counter; the counter wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore control outputs. The only input-dependent terms
    // are the memory-ready gating in the memory states and the opcode
    // dispatch in DECODE / MEMADR.
    always_comb begin
        next_state    = state;
        pc_update     = 1'b0;
        branch        = 1'b0;
        retire        = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;

        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (ready) begin
                    ir_write   = 1'b1;
                    pc_update  = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default: begin
                        illegal_instr = 1'b1;
                        next_state    = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (ready) begin
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                // The write strobe stays up through the cycle memory accepts it.
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                // PC takes the target from ALUOut while PC+4 is formed for rd.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode directly so it is ready in DECODE.
    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
//   Directed bench for multicycle_control_fsm. Two instances share stimulus:
//   dut traps on illegal opcodes, dut_nt returns to FETCH instead.
//   Control outputs are packed into one word per instance so that each cycle
//   of an instruction can be compared against a hand-written expected word.

module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0110111;

    // Word layout: pc_write adr_src mem_write ir_write reg_write
    //              result_src alu_src_a alu_src_b alu_op illegal_instr
    localparam logic [13:0] FETCH_RDY  = 14'b1_0_0_1_0_10_00_10_00_0;
    localparam logic [13:0] FETCH_IDLE = 14'b0_0_0_0_0_10_00_10_00_0;
    localparam logic [13:0] DEC_OK     = 14'b0_0_0_0_0_00_01_01_00_0;
    localparam logic [13:0] DEC_ILL    = 14'b0_0_0_0_0_00_01_01_00_1;
    localparam logic [13:0] MEMADR_W   = 14'b0_0_0_0_0_00_10_01_00_0;
    localparam logic [13:0] MEMREAD_W  = 14'b0_1_0_0_0_00_00_00_00_0;
    localparam logic [13:0] MEMWB_W    = 14'b0_0_0_0_1_01_00_00_00_0;
    localparam logic [13:0] MEMWRITE_W = 14'b0_1_1_0_0_00_00_00_00_0;
    localparam logic [13:0] EXECR_W    = 14'b0_0_0_0_0_00_10_00_10_0;
    localparam logic [13:0] EXECI_W    = 14'b0_0_0_0_0_00_10_01_10_0;
    localparam logic [13:0] ALUWB_W    = 14'b0_0_0_0_1_00_00_00_00_0;
    localparam logic [13:0] JAL_W      = 14'b1_0_0_0_0_00_01_10_00_0;
    localparam logic [13:0] BEQ_T      = 14'b1_0_0_0_0_00_10_00_01_0;
    localparam logic [13:0] BEQ_N      = 14'b0_0_0_0_0_00_10_00_01_0;
    localparam logic [13:0] TRAP_W     = 14'b0_0_0_0_0_00_00_00_00_1;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic        mem_ready;
    logic        zero;

    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [31:0] instret;

    logic        pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal_instr2;
    logic [1:0]  result_src2, alu_src_a2, alu_src_b2, alu_op2, imm_src2;
    logic [31:0] instret2;

    logic [13:0] ctl, ctl2;

    int checks = 0;
    int passes = 0;

    assign ctl  = {pc_write, adr_src, mem_write, ir_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};
    assign ctl2 = {pc_write2, adr_src2, mem_write2, ir_write2, reg_write2,
                   result_src2, alu_src_a2, alu_src_b2, alu_op2, illegal_instr2};

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_src(imm_src), .illegal_instr(illegal_instr), .instret(instret)
    );

    multicycle_control_fsm #(
        .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)
    ) dut_nt (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .zero(zero),
        .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2),
        .ir_write(ir_write2), .reg_write(reg_write2), .result_src(result_src2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
        .imm_src(imm_src2), .illegal_instr(illegal_instr2), .instret(instret2)
    );

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 7'd0; mem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== FETCH_IDLE) $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, FETCH_IDLE);
        else passes++;
        checks++;
        if (instret !== 32'd0) $display("[TB] FAIL reset_instret: got %0d expected 0", instret);
        else passes++;
        checks++;
        if (ctl2 !== FETCH_IDLE || instret2 !== 32'd0)
            $display("[TB] FAIL reset_nt: got %b/%0d expected %b/0", ctl2, instret2, FETCH_IDLE);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [13:0] seq [5];
        seq = '{FETCH_RDY, DEC_OK, MEMADR_W, MEMREAD_W, MEMWB_W};
        op = OP_LW; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== seq[i]) $display("[TB] FAIL lw_cycle%0d: got %b expected %b", i, ctl, seq[i]);
            else passes++;
            if (i == 1) begin
                checks++;
                if (imm_src !== 2'b00) $display("[TB] FAIL lw_imm_src: got %b expected 00", imm_src);
                else passes++;
            end
            step();
        end
        checks++;
        if (instret !== 32'd1) $display("[TB] FAIL lw_instret: got %0d expected 1", instret);
        else passes++;
    endtask

    task automatic test_sw_stall();
        op = OP_SW; mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== FETCH_RDY) $display("[TB] FAIL sw_fetch: got %b expected %b", ctl, FETCH_RDY);
        else passes++;
        step(); #1;
        checks++;
        if (ctl !== DEC_OK || imm_src !== 2'b01)
            $display("[TB] FAIL sw_decode: got %b/%b expected %b/01", ctl, imm_src, DEC_OK);
        else passes++;
        step(); #1;
        checks++;
        if (ctl !== MEMADR_W) $display("[TB] FAIL sw_memadr: got %b expected %b", ctl, MEMADR_W);
        else passes++;
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== MEMWRITE_W || instret !== 32'd1)
                $display("[TB] FAIL sw_stall%0d: got %b/%0d expected %b/1", i, ctl, instret, MEMWRITE_W);
            else passes++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== MEMWRITE_W || instret !== 32'd1)
            $display("[TB] FAIL sw_ready: got %b/%0d expected %b/1", ctl, instret, MEMWRITE_W);
        else passes++;
        step(); #1;
        checks++;
        if (ctl !== FETCH_RDY || instret !== 32'd2)
            $display("[TB] FAIL sw_done: got %b/%0d expected %b/2", ctl, instret, FETCH_RDY);
        else passes++;
    endtask

    task automatic test_beq();
        logic [13:0] beq_exp [2];
        logic [31:0] cnt_exp [2];
        beq_exp = '{BEQ_T, BEQ_N};
        cnt_exp = '{32'd3, 32'd4};
        op = OP_BEQ; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            #1;
            checks++;
            if (ctl !== FETCH_RDY) $display("[TB] FAIL beq%0d_fetch: got %b expected %b", k, ctl, FETCH_RDY);
            else passes++;
            step(); #1;
            checks++;
            if (ctl !== DEC_OK || imm_src !== 2'b10)
                $display("[TB] FAIL beq%0d_decode: got %b/%b expected %b/10", k, ctl, imm_src, DEC_OK);
            else passes++;
            step(); #1;
            checks++;
            if (ctl !== beq_exp[k]) $display("[TB] FAIL beq%0d_exec: got %b expected %b", k, ctl, beq_exp[k]);
            else passes++;
            step();
            checks++;
            if (instret !== cnt_exp[k]) $display("[TB] FAIL beq%0d_instret: got %0d expected %0d", k, instret, cnt_exp[k]);
            else passes++;
        end
        zero = 1'b0;
    endtask

    task automatic test_alu_jal();
        logic [6:0]  ops [3];
        logic [13:0] exe [3];
        logic [1:0]  imm [3];
        ops = '{OP_R, OP_I, OP_JAL};
        exe = '{EXECR_W, EXECI_W, JAL_W};
        imm = '{2'b00, 2'b00, 2'b11};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            step();
            #1;
            checks++;
            if (ctl !== DEC_OK || imm_src !== imm[k])
                $display("[TB] FAIL alu%0d_decode: got %b/%b expected %b/%b", k, ctl, imm_src, DEC_OK, imm[k]);
            else passes++;
            step(); #1;
            checks++;
            if (ctl !== exe[k]) $display("[TB] FAIL alu%0d_exec: got %b expected %b", k, ctl, exe[k]);
            else passes++;
            step(); #1;
            checks++;
            if (ctl !== ALUWB_W) $display("[TB] FAIL alu%0d_wb: got %b expected %b", k, ctl, ALUWB_W);
            else passes++;
            step();
            checks++;
            if (instret !== 32'd5 + 32'(k)) $display("[TB] FAIL alu%0d_instret: got %0d expected %0d", k, instret, 5 + k);
            else passes++;
        end
    endtask

    task automatic test_illegal();
        op = OP_BAD; mem_ready = 1'b1;
        step(); #1;
        checks++;
        if (ctl !== DEC_ILL || imm_src !== 2'b00)
            $display("[TB] FAIL ill_decode: got %b/%b expected %b/00", ctl, imm_src, DEC_ILL);
        else passes++;
        checks++;
        if (ctl2 !== DEC_ILL) $display("[TB] FAIL ill_decode_nt: got %b expected %b", ctl2, DEC_ILL);
        else passes++;
        step(); #1;
        checks++;
        if (ctl2 !== FETCH_RDY) $display("[TB] FAIL ill_refetch_nt: got %b expected %b", ctl2, FETCH_RDY);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== TRAP_W || instret !== 32'd7)
                $display("[TB] FAIL ill_trap%0d: got %b/%0d expected %b/7", i, ctl, instret, TRAP_W);
            else passes++;
            step();
        end
        checks++;
        if (instret2 !== 32'd7) $display("[TB] FAIL ill_instret_nt: got %0d expected 7", instret2);
        else passes++;
        reset = 1'b1;
        step();
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== FETCH_IDLE || instret !== 32'd0)
            $display("[TB] FAIL ill_reset: got %b/%0d expected %b/0", ctl, instret, FETCH_IDLE);
        else passes++;
    endtask

    task automatic test_stall_reset();
        op = OP_R; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== FETCH_IDLE) $display("[TB] FAIL stall%0d: got %b expected %b", i, ctl, FETCH_IDLE);
            else passes++;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== FETCH_IDLE || instret !== 32'd0)
            $display("[TB] FAIL stall_reset: got %b/%0d expected %b/0", ctl, instret, FETCH_IDLE);
        else passes++;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== FETCH_RDY) $display("[TB] FAIL stall_resume: got %b expected %b", ctl, FETCH_RDY);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_alu_jal();
        test_illegal();
        test_stall_reset();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
